// File: rtl/alu_issue_queue.sv
// Value-capturing ALU issue queue: collapsing age-ordered storage, dual writeback snoop,
// oldest-ready select into a registered issue stage.
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module alu_issue_queue #(
    parameter int DEPTH         = 8,
    parameter int PTAG_WIDTH    = 6,
    parameter int ROB_TAG_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    input  logic [`DATA_WIDTH_ALU_OP-1:0] dispatch_op,
    input  logic [`PC_WIDTH-1:0]          dispatch_pc,
    input  logic [`WORD_WIDTH-1:0]        dispatch_imm,
    input  logic [ROB_TAG_WIDTH-1:0]      dispatch_rob_tag,
    input  logic [PTAG_WIDTH-1:0]         dispatch_rd_ptag,
    input  logic [PTAG_WIDTH-1:0]         dispatch_rs1_ptag,
    input  logic [PTAG_WIDTH-1:0]         dispatch_rs2_ptag,
    input  logic                          dispatch_rs1_ready,
    input  logic                          dispatch_rs2_ready,
    input  logic [`WORD_WIDTH-1:0]        dispatch_rs1_value,
    input  logic [`WORD_WIDTH-1:0]        dispatch_rs2_value,
    input  logic                          wb0_valid,
    input  logic [PTAG_WIDTH-1:0]         wb0_ptag,
    input  logic [`WORD_WIDTH-1:0]        wb0_value,
    input  logic                          wb1_valid,
    input  logic [PTAG_WIDTH-1:0]         wb1_ptag,
    input  logic [`WORD_WIDTH-1:0]        wb1_value,
    output logic                          alu_issue_en,
    output logic [`DATA_WIDTH_ALU_OP-1:0] alu_issue_queue_op,
    output logic [`PC_WIDTH-1:0]          alu_issue_queue_pc,
    output logic [`WORD_WIDTH-1:0]        alu_issue_queue_imm,
    output logic [`WORD_WIDTH-1:0]        alu_issue_queue_rs1_value,
    output logic [`WORD_WIDTH-1:0]        alu_issue_queue_rs2_value,
    output logic [ROB_TAG_WIDTH-1:0]      alu_issue_rob_tag,
    output logic [PTAG_WIDTH-1:0]         alu_issue_rd_ptag
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    typedef struct packed {
        logic [`DATA_WIDTH_ALU_OP-1:0] op;
        logic [`PC_WIDTH-1:0]          pc;
        logic [`WORD_WIDTH-1:0]        imm;
        logic [ROB_TAG_WIDTH-1:0]      rob_tag;
        logic [PTAG_WIDTH-1:0]         rd_ptag;
        logic [PTAG_WIDTH-1:0]         rs1_ptag;
        logic                          rs1_ready;
        logic [`WORD_WIDTH-1:0]        rs1_value;
        logic [PTAG_WIDTH-1:0]         rs2_ptag;
        logic                          rs2_ready;
        logic [`WORD_WIDTH-1:0]        rs2_value;
    } entry_t;

    entry_t         q   [DEPTH];
    entry_t         q_n [DEPTH];
    entry_t         ent_in;
    logic [CW-1:0]  count, count_n, wr_idx;
    logic [SW-1:0]  sel;
    logic           issue, accept;

    // Capture a broadcast into any still-pending source; wb0 has priority over wb1.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        if (!r.rs1_ready) begin
            if (wb0_valid && wb0_ptag == r.rs1_ptag) begin
                r.rs1_ready = 1'b1; r.rs1_value = wb0_value;
            end else if (wb1_valid && wb1_ptag == r.rs1_ptag) begin
                r.rs1_ready = 1'b1; r.rs1_value = wb1_value;
            end
        end
        if (!r.rs2_ready) begin
            if (wb0_valid && wb0_ptag == r.rs2_ptag) begin
                r.rs2_ready = 1'b1; r.rs2_value = wb0_value;
            end else if (wb1_valid && wb1_ptag == r.rs2_ptag) begin
                r.rs2_ready = 1'b1; r.rs2_value = wb1_value;
            end
        end
        return r;
    endfunction

    assign dispatch_ready = (count != CW'(DEPTH));
    assign accept         = dispatch_valid && dispatch_ready;

    always_comb begin
        issue = 1'b0;
        sel   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (CW'(k) < count && q[k].rs1_ready && q[k].rs2_ready) begin
                issue = 1'b1;
                sel   = SW'(k);
            end
        end
    end

    always_comb begin
        ent_in = wake('{op: dispatch_op, pc: dispatch_pc, imm: dispatch_imm,
                        rob_tag: dispatch_rob_tag, rd_ptag: dispatch_rd_ptag,
                        rs1_ptag: dispatch_rs1_ptag, rs1_ready: dispatch_rs1_ready,
                        rs1_value: dispatch_rs1_value,
                        rs2_ptag: dispatch_rs2_ptag, rs2_ready: dispatch_rs2_ready,
                        rs2_value: dispatch_rs2_value});
        // Entries at and above the selected slot collapse down by one.
        for (int k = 0; k < DEPTH - 1; k++)
            q_n[k] = (issue && SW'(k) >= sel) ? wake(q[k+1]) : wake(q[k]);
        q_n[DEPTH-1] = issue ? q[DEPTH-1] : wake(q[DEPTH-1]);
        wr_idx  = count - CW'(issue);
        if (accept) begin
            for (int k = 0; k < DEPTH; k++)
                if (CW'(k) == wr_idx) q_n[k] = ent_in;
        end
        count_n = count + CW'(accept) - CW'(issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) q[k] <= '0;
            count                     <= '0;
            alu_issue_en              <= 1'b0;
            alu_issue_queue_op        <= '0;
            alu_issue_queue_pc        <= '0;
            alu_issue_queue_imm       <= '0;
            alu_issue_queue_rs1_value <= '0;
            alu_issue_queue_rs2_value <= '0;
            alu_issue_rob_tag         <= '0;
            alu_issue_rd_ptag         <= '0;
        end else if (flush) begin
            count        <= '0;
            alu_issue_en <= 1'b0;
        end else begin
            q            <= q_n;
            count        <= count_n;
            alu_issue_en <= issue;
            if (issue) begin
                alu_issue_queue_op        <= q[sel].op;
                alu_issue_queue_pc        <= q[sel].pc;
                alu_issue_queue_imm       <= q[sel].imm;
                alu_issue_queue_rs1_value <= q[sel].rs1_value;
                alu_issue_queue_rs2_value <= q[sel].rs2_value;
                alu_issue_rob_tag         <= q[sel].rob_tag;
                alu_issue_rd_ptag         <= q[sel].rd_ptag;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against a queue-based age-order model.
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_alu_issue_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 6;
    localparam int RW    = 5;
    localparam int OW    = `DATA_WIDTH_ALU_OP;
    localparam int PCW   = `PC_WIDTH;
    localparam int WW    = `WORD_WIDTH;

    logic           clk = 1'b0, rst_n = 1'b0, flush;
    logic           dispatch_valid, dispatch_ready;
    logic [OW-1:0]  dispatch_op;
    logic [PCW-1:0] dispatch_pc;
    logic [WW-1:0]  dispatch_imm;
    logic [RW-1:0]  dispatch_rob_tag;
    logic [PW-1:0]  dispatch_rd_ptag, dispatch_rs1_ptag, dispatch_rs2_ptag;
    logic           dispatch_rs1_ready, dispatch_rs2_ready;
    logic [WW-1:0]  dispatch_rs1_value, dispatch_rs2_value;
    logic           wb0_valid, wb1_valid;
    logic [PW-1:0]  wb0_ptag, wb1_ptag;
    logic [WW-1:0]  wb0_value, wb1_value;
    logic           alu_issue_en;
    logic [OW-1:0]  alu_issue_queue_op;
    logic [PCW-1:0] alu_issue_queue_pc;
    logic [WW-1:0]  alu_issue_queue_imm, alu_issue_queue_rs1_value, alu_issue_queue_rs2_value;
    logic [RW-1:0]  alu_issue_rob_tag;
    logic [PW-1:0]  alu_issue_rd_ptag;

    alu_issue_queue #(.DEPTH(DEPTH), .PTAG_WIDTH(PW), .ROB_TAG_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
        .dispatch_rob_tag(dispatch_rob_tag), .dispatch_rd_ptag(dispatch_rd_ptag),
        .dispatch_rs1_ptag(dispatch_rs1_ptag), .dispatch_rs2_ptag(dispatch_rs2_ptag),
        .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
        .wb0_valid(wb0_valid), .wb0_ptag(wb0_ptag), .wb0_value(wb0_value),
        .wb1_valid(wb1_valid), .wb1_ptag(wb1_ptag), .wb1_value(wb1_value),
        .alu_issue_en(alu_issue_en), .alu_issue_queue_op(alu_issue_queue_op),
        .alu_issue_queue_pc(alu_issue_queue_pc), .alu_issue_queue_imm(alu_issue_queue_imm),
        .alu_issue_queue_rs1_value(alu_issue_queue_rs1_value),
        .alu_issue_queue_rs2_value(alu_issue_queue_rs2_value),
        .alu_issue_rob_tag(alu_issue_rob_tag), .alu_issue_rd_ptag(alu_issue_rd_ptag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0]  op;
        logic [PCW-1:0] pc;
        logic [WW-1:0]  imm;
        logic [RW-1:0]  rob;
        logic [PW-1:0]  rd, t1, t2;
        bit             r1, r2;
        logic [WW-1:0]  v1, v2;
    } uop_t;

    uop_t          mq[$];
    uop_t          exp_u;
    bit            exp_en;
    logic [RW-1:0] issued_rob[$];
    int            checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic uop_t wk(input uop_t u);
        uop_t r = u;
        if (!r.r1 && wb0_valid && wb0_ptag == r.t1)      begin r.r1 = 1; r.v1 = wb0_value; end
        else if (!r.r1 && wb1_valid && wb1_ptag == r.t1) begin r.r1 = 1; r.v1 = wb1_value; end
        if (!r.r2 && wb0_valid && wb0_ptag == r.t2)      begin r.r2 = 1; r.v2 = wb0_value; end
        else if (!r.r2 && wb1_valid && wb1_ptag == r.t2) begin r.r2 = 1; r.v2 = wb1_value; end
        return r;
    endfunction

    function automatic uop_t rand_uop();
        uop_t u;
        u.op  = OW'($urandom);  u.pc = PCW'($urandom); u.imm = WW'($urandom);
        u.rob = RW'($urandom);  u.rd = PW'($urandom);
        u.t1  = PW'($urandom_range(0, 15)); u.t2 = PW'($urandom_range(0, 15));
        u.r1  = ($urandom_range(0, 2) != 0); u.r2 = ($urandom_range(0, 2) != 0);
        u.v1  = WW'($urandom);  u.v2 = WW'($urandom);
        return u;
    endfunction

    task automatic idle();
        dispatch_valid = 0; wb0_valid = 0; wb1_valid = 0; flush = 0;
    endtask

    task automatic set_disp(input uop_t u);
        dispatch_valid = 1;
        dispatch_op = u.op; dispatch_pc = u.pc; dispatch_imm = u.imm;
        dispatch_rob_tag = u.rob; dispatch_rd_ptag = u.rd;
        dispatch_rs1_ptag = u.t1; dispatch_rs1_ready = u.r1; dispatch_rs1_value = u.v1;
        dispatch_rs2_ptag = u.t2; dispatch_rs2_ready = u.r2; dispatch_rs2_value = u.v2;
    endtask

    task automatic set_wb(input int port, input logic [PW-1:0] t, input logic [WW-1:0] v);
        if (port == 0) begin wb0_valid = 1; wb0_ptag = t; wb0_value = v; end
        else           begin wb1_valid = 1; wb1_ptag = t; wb1_value = v; end
    endtask

    // Advance model and DUT one clock, then compare.
    task automatic cycle();
        int   sel;
        bit   acc;
        uop_t nu;
        if (flush) begin
            mq.delete(); exp_en = 0;
        end else begin
            sel = -1;
            foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            acc = dispatch_valid && (mq.size() < DEPTH);
            nu.op = dispatch_op; nu.pc = dispatch_pc; nu.imm = dispatch_imm;
            nu.rob = dispatch_rob_tag; nu.rd = dispatch_rd_ptag;
            nu.t1 = dispatch_rs1_ptag; nu.r1 = dispatch_rs1_ready; nu.v1 = dispatch_rs1_value;
            nu.t2 = dispatch_rs2_ptag; nu.r2 = dispatch_rs2_ready; nu.v2 = dispatch_rs2_value;
            nu = wk(nu);
            if (sel >= 0) begin
                exp_u = mq[sel]; mq.delete(sel); exp_en = 1;
            end else exp_en = 0;
            foreach (mq[i]) mq[i] = wk(mq[i]);
            if (acc) mq.push_back(nu);
        end
        @(posedge clk); #1;
        chk("issue_en", 64'(alu_issue_en), 64'(exp_en));
        chk("dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < DEPTH));
        if (exp_en && alu_issue_en) begin
            issued_rob.push_back(alu_issue_rob_tag);
            chk("op",  64'(alu_issue_queue_op),        64'(exp_u.op));
            chk("pc",  64'(alu_issue_queue_pc),        64'(exp_u.pc));
            chk("imm", 64'(alu_issue_queue_imm),       64'(exp_u.imm));
            chk("rs1", 64'(alu_issue_queue_rs1_value), 64'(exp_u.v1));
            chk("rs2", 64'(alu_issue_queue_rs2_value), 64'(exp_u.v2));
            chk("rob", 64'(alu_issue_rob_tag),         64'(exp_u.rob));
            chk("rd",  64'(alu_issue_rd_ptag),         64'(exp_u.rd));
        end
    endtask

    task automatic mid_reset();
        rst_n = 0; #2;
        chk("rst_issue_en", 64'(alu_issue_en), 64'd0);
        chk("rst_ready", 64'(dispatch_ready), 64'd1);
        mq.delete(); exp_en = 0;
        @(negedge clk); rst_n = 1;
        idle();
        cycle();
    endtask

    initial begin
        uop_t u;
        idle();
        u = rand_uop(); set_disp(u); dispatch_valid = 0;
        wb0_ptag = '0; wb1_ptag = '0; wb0_value = '0; wb1_value = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        chk("reset_issue_en", 64'(alu_issue_en), 64'd0);
        chk("reset_ready", 64'(dispatch_ready), 64'd1);
        @(posedge clk); #1;

        // Ready ADDI issues the cycle after dispatch, for one cycle.
        u = rand_uop(); u.op = 4'h1; u.r1 = 1; u.v1 = 5; u.r2 = 1; u.imm = 3;
        set_disp(u); cycle();
        idle(); cycle();
        chk("addi_rs1", 64'(alu_issue_queue_rs1_value), 64'd5);
        chk("addi_imm", 64'(alu_issue_queue_imm), 64'd3);
        cycle();

        // Wakeup via wb1.
        u = rand_uop(); u.r1 = 1; u.r2 = 0; u.t2 = 12;
        set_disp(u); cycle();
        idle(); cycle(); cycle();
        set_wb(1, 6'd12, 32'hDEAD); cycle();
        idle(); cycle();
        chk("wake_rs2", 64'(alu_issue_queue_rs2_value), 64'hDEAD);
        cycle();

        // Age order with a stale re-broadcast.
        issued_rob.delete();
        u = rand_uop(); u.rob = 5'd1; u.r1 = 0; u.t1 = 20; u.r2 = 0; u.t2 = 21;
        set_disp(u); cycle();
        u = rand_uop(); u.rob = 5'd2; u.r1 = 1; u.r2 = 1; set_disp(u); cycle();
        u = rand_uop(); u.rob = 5'd3; u.r1 = 1; u.r2 = 1; set_disp(u); cycle();
        idle(); set_wb(0, 6'd20, 32'h1111); cycle();
        idle(); set_wb(1, 6'd20, 32'h2222); cycle();
        idle(); set_wb(0, 6'd21, 32'h3333); cycle();
        idle(); repeat (3) cycle();
        chk("order_n", 64'(issued_rob.size()), 64'd3);
        if (issued_rob.size() == 3) begin
            chk("order0", 64'(issued_rob[0]), 64'd2);
            chk("order1", 64'(issued_rob[1]), 64'd3);
            chk("order2", 64'(issued_rob[2]), 64'd1);
        end

        // Full queue back-pressure.
        for (int i = 0; i < DEPTH; i++) begin
            u = rand_uop(); u.r1 = 0; u.t1 = PW'(40 + i); u.r2 = 1; set_disp(u); cycle();
        end
        chk("full_ready", 64'(dispatch_ready), 64'd0);
        u = rand_uop(); u.r1 = 1; u.r2 = 1; set_disp(u); cycle(); cycle();
        set_wb(0, 6'd40, 32'h4040); cycle();
        wb0_valid = 0; cycle(); cycle();
        idle(); repeat (2) cycle();

        // Flush with concurrent dispatch and wakeup.
        flush = 1; cycle(); idle();
        for (int i = 0; i < 4; i++) begin
            u = rand_uop(); u.r1 = 0; u.t1 = PW'(50 + i); u.r2 = 1; set_disp(u); cycle();
        end
        u = rand_uop(); u.r1 = 1; u.r2 = 1; set_disp(u);
        set_wb(0, 6'd50, 32'h5050); flush = 1; cycle();
        chk("flush_en", 64'(alu_issue_en), 64'd0);
        idle(); set_wb(1, 6'd51, 32'h5151); cycle();
        idle(); repeat (3) cycle();

        // Random traffic with occasional flush and one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if (n == 1500) begin
                mid_reset();
            end else begin
                if ($urandom_range(0, 9) < 6) begin u = rand_uop(); set_disp(u); end
                if ($urandom_range(0, 9) < 3) set_wb(0, PW'($urandom_range(0, 15)), WW'($urandom));
                if ($urandom_range(0, 9) < 3) set_wb(1, PW'($urandom_range(0, 15)), WW'($urandom));
                flush = ($urandom_range(0, 99) == 0);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
